// File: rtl/expr_result_unpacker.sv
// Unpacks the 90-bit vloghammer result bus into 18 extended beats
// plus a trailing XOR checksum beat.
module expr_result_unpacker #(
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [89:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [4:0]       out_idx,
  output logic             out_signed,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] frames_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_CSUM
  } state_t;

  state_t           r_state, w_state;
  logic [89:0]      r_frame, w_frame;
  logic [OUT_W-1:0] r_csum, w_csum;
  logic [OUT_W-1:0] r_data, w_data;
  logic [4:0]       r_idx, w_idx;
  logic             r_valid, w_valid;
  logic             r_sgn, w_sgn;
  logic             r_last, w_last;
  logic             r_in_rdy, w_in_rdy;
  logic             r_busy, w_busy;
  logic [CNT_W-1:0] r_done, w_done;
  logic             w_hs;
  logic [OUT_W:0]   w_fld;

  // Returns {signed, extended value} for field idx of frame f.
  function automatic logic [OUT_W:0] f_field(
    input logic [89:0] f,
    input logic [4:0]  idx
  );
    logic [89:0]      sh;
    logic [5:0]       raw;
    logic [OUT_W-1:0] m;
    logic [OUT_W-1:0] v;
    logic             sg;
    int               g, k, off, w, lsb;
    g = int'(idx) / 6;
    k = int'(idx) % 6;
    unique case (k)
      0:       begin off = 0;  w = 4; end
      1:       begin off = 4;  w = 5; end
      2:       begin off = 9;  w = 6; end
      3:       begin off = 15; w = 4; end
      4:       begin off = 19; w = 5; end
      default: begin off = 24; w = 6; end
    endcase
    sg  = (k >= 3);
    lsb = 89 - 30 * g - off - w + 1;
    sh  = f >> lsb;
    raw = sh[5:0];
    m   = ~({OUT_W{1'b1}} << w);
    v   = OUT_W'(raw) & m;
    if (sg && raw[w-1])
      v = v | ~m;
    return {sg, v};
  endfunction

  assign w_hs = r_valid && out_ready;

  always_comb begin
    w_state = r_state;
    w_frame = r_frame;
    w_csum  = r_csum;
    w_data  = r_data;
    w_idx   = r_idx;
    w_valid = r_valid;
    w_sgn   = r_sgn;
    w_last  = r_last;
    w_done  = r_done;
    w_fld   = '0;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_fld   = f_field(in_data, 5'd0);
          w_frame = in_data;
          w_csum  = '0;
          w_idx   = 5'd0;
          w_state = S_SEND;
          w_valid = 1'b1;
          w_sgn   = w_fld[OUT_W];
          w_data  = w_fld[OUT_W-1:0];
          w_last  = 1'b0;
        end
      end
      S_SEND: begin
        if (w_hs) begin
          w_csum = r_csum ^ r_data;
          if (r_idx == 5'd17) begin
            w_state = S_CSUM;
            w_idx   = 5'd18;
            w_data  = r_csum ^ r_data;
            w_sgn   = 1'b0;
            w_last  = 1'b1;
          end else begin
            w_idx  = r_idx + 5'd1;
            w_fld  = f_field(r_frame, w_idx);
            w_sgn  = w_fld[OUT_W];
            w_data = w_fld[OUT_W-1:0];
          end
        end
      end
      S_CSUM: begin
        if (w_hs) begin
          w_state = S_IDLE;
          w_valid = 1'b0;
          w_data  = '0;
          w_idx   = 5'd0;
          w_last  = 1'b0;
          w_done  = r_done + CNT_W'(1);
        end
      end
      default: begin
        w_state = S_IDLE;
        w_valid = 1'b0;
      end
    endcase
    w_in_rdy = (w_state == S_IDLE);
    w_busy   = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_frame  <= '0;
      r_csum   <= '0;
      r_data   <= '0;
      r_idx    <= '0;
      r_valid  <= 1'b0;
      r_sgn    <= 1'b0;
      r_last   <= 1'b0;
      r_in_rdy <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= '0;
    end else begin
      r_state  <= w_state;
      r_frame  <= w_frame;
      r_csum   <= w_csum;
      r_data   <= w_data;
      r_idx    <= w_idx;
      r_valid  <= w_valid;
      r_sgn    <= w_sgn;
      r_last   <= w_last;
      r_in_rdy <= w_in_rdy;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  assign in_ready    = r_in_rdy;
  assign out_valid   = r_valid;
  assign out_data    = r_data;
  assign out_idx     = r_idx;
  assign out_signed  = r_sgn;
  assign out_last    = r_last;
  assign busy        = r_busy;
  assign frames_done = r_done;

endmodule

// File: tb/tb_expr_result_unpacker.sv
// Directed bench for expr_result_unpacker: field extension,
// checksum, backpressure, async reset and back-to-back frames.
module tb_expr_result_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [89:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [4:0]  out_idx;
  logic        out_signed;
  logic        out_last;
  logic        busy;
  logic [15:0] frames_done;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] b_data [0:31];
  logic [4:0] b_idx  [0:31];
  logic       b_sgn  [0:31];
  logic       b_last [0:31];
  int         nb;

  logic [7:0] ones_tab [0:5];

  always #5 clk = ~clk;

  expr_result_unpacker #(.OUT_W(8), .CNT_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_idx(out_idx),
    .out_signed(out_signed),
    .out_last(out_last),
    .busy(busy),
    .frames_done(frames_done)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [89:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    check("first_beat_valid", out_valid, 1);
    check("busy_in_frame", busy, 1);
    check("in_ready_low", in_ready, 0);
  endtask

  task automatic collect(input int stall_idx);
    bit stalled;
    int cyc;
    stalled = 0;
    cyc = 0;
    nb = 0;
    while (cyc < 200) begin
      if (out_valid && out_idx == stall_idx && !stalled) begin
        stalled = 1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_valid", out_valid, 1);
          check("stall_idx", out_idx, stall_idx);
          check("stall_data", out_data, 8'hFF);
        end
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        b_data[nb] = out_data;
        b_idx[nb]  = out_idx;
        b_sgn[nb]  = out_signed;
        b_last[nb] = out_last;
        nb++;
        if (out_last) begin
          @(negedge clk);
          return;
        end
      end
      @(negedge clk);
      cyc++;
    end
    check("collect_timeout", 0, 1);
  endtask

  task automatic check_ones_frame();
    check("beat_count", nb, 19);
    for (int i = 0; i < 18; i++) begin
      check("ones_data", b_data[i], ones_tab[i%6]);
      check("ones_idx", b_idx[i], i);
      check("ones_sgn", b_sgn[i], (i % 6) >= 3);
    end
    check("ones_csum", b_data[18], 8'hD0);
    check("ones_csum_idx", b_idx[18], 18);
    check("ones_last", b_last[18], 1);
    check("ones_csum_sgn", b_sgn[18], 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int acc;
    int acc_pos [0:3];
    int rdy_bad;
    ones_tab[0] = 8'h0F; ones_tab[1] = 8'h1F; ones_tab[2] = 8'h3F;
    ones_tab[3] = 8'hFF; ones_tab[4] = 8'hFF; ones_tab[5] = 8'hFF;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frames", frames_done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // all-ones frame
    send_frame({90{1'b1}});
    collect(99);
    check_ones_frame();
    check("frames_after_1", frames_done, 1);
    check("idle_ready", in_ready, 1);

    // backpressure at idx 4
    send_frame({90{1'b1}});
    collect(4);
    check_ones_frame();
    check("frames_after_2", frames_done, 2);

    // async reset mid-frame at idx 9
    send_frame({90{1'b1}});
    cyc = 0;
    while (out_idx != 5'd9 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_idx9", out_idx, 9);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_idx", out_idx, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_frames", frames_done, 0);
    check("mid_rst_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);

    // single lsb set: field 17
    send_frame(90'h1);
    check("h1_first_idx", out_idx, 0);
    collect(99);
    check("h1_count", nb, 19);
    for (int i = 0; i < 17; i++)
      check("h1_zero", b_data[i], 0);
    check("h1_f17", b_data[17], 8'h01);
    check("h1_f17_sgn", b_sgn[17], 1);
    check("h1_csum", b_data[18], 8'h01);
    check("h1_frames", frames_done, 1);

    // y3 = 4'b1000 sign-extends
    send_frame(90'h1 << 74);
    collect(99);
    check("y3_data", b_data[3], 8'hF8);
    check("y3_sgn", b_sgn[3], 1);
    check("y3_f2", b_data[2], 8'h00);
    check("y3_csum", b_data[18], 8'hF8);
    check("y3_frames", frames_done, 2);

    // three back-to-back frames, in_valid held high
    pulse_reset();
    acc = 0;
    rdy_bad = 0;
    in_valid = 1'b1;
    in_data  = {90{1'b1}};
    for (int k = 0; k < 60; k++) begin
      if (in_ready == busy) rdy_bad++;
      if (in_valid && in_ready) begin
        if (acc < 4) acc_pos[acc] = k;
        acc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_accepts", acc, 3);
    check("b2b_pos0", acc_pos[0], 0);
    check("b2b_pos1", acc_pos[1], 20);
    check("b2b_pos2", acc_pos[2], 40);
    check("b2b_ready_vs_busy", rdy_bad, 0);
    repeat (3) @(negedge clk);
    check("b2b_frames", frames_done, 3);
    check("b2b_idle", busy, 0);
    check("b2b_no_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
